// File: rtl/tdm_demux.sv
// tdm_demux: serial time-division demultiplexer.
// Slots arrive one per accepted (VALID) cycle. FRAME marks slot 0. A frame
// with N_CH slots is collected into a shadow register. When the frame is
// complete, the whole frame is published to DOUT at the same time.
// A frame is aborted, with an ERR pulse, if FRAME arrives early or if the
// line stays idle for too long in the middle of a frame.
module tdm_demux #(
  parameter int N_CH     = 4,   // demultiplexed channels, 2..16
  parameter int FRAME_TO = 8    // idle cycles tolerated mid-frame, 1..255
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    DIN,
  input  logic                    VALID,
  input  logic                    FRAME,
  output logic [N_CH-1:0]         DOUT,
  output logic                    DOUT_VLD,
  output logic [$clog2(N_CH)-1:0] SLOT,
  output logic                    ERR
);

  localparam int SW = $clog2(N_CH);

  // Index of the final slot in a frame. Capturing this slot completes the frame.
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

  // The stall counter stops at FRAME_TO. The abort happens on the idle cycle
  // that would move the counter to that value, so it is compared against
  // FRAME_TO-1.
  localparam logic [7:0] STALL_LIM = 8'(FRAME_TO - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_slot;
  logic [N_CH-1:0] r_shadow;
  logic [7:0]      r_stall;
  logic [N_CH-1:0] r_dout;
  logic            r_dout_vld;
  logic            r_err;

  logic            w_din;
  logic [N_CH-1:0] w_first;
  logic [N_CH-1:0] w_frame_full;

  // An unknown or floating line is taken as 0, never as a 1 bit of data.
  assign w_din = (DIN === 1'b1);

  // Shadow contents for a frame starting on this cycle. Only slot 0 is filled,
  // so bits from an earlier partial frame are never carried over.
  always_comb begin
    // NOTE: set every always_comb output to a default first. A path that does
    // not assign the output would otherwise infer a latch.
    w_first    = '0;
    w_first[0] = w_din;
  end

  // Completed frame: all earlier slots are in the shadow, and the last slot
  // arrives on DIN in this cycle.
  always_comb begin
    w_frame_full            = r_shadow;
    w_frame_full[N_CH-1]    = w_din;
  end

  // Frame-collection FSM with registered outputs.
  // DOUT_VLD and ERR are set only on separate branches, so they cannot be
  // high together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the shadow is reset together with the control state. A partial
      // frame from before reset can then never be combined with new slots.
      r_state    <= ST_IDLE;
      r_slot     <= '0;
      r_shadow   <= '0;
      r_stall    <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // branch below then reads values from before the clock edge.
      r_dout_vld <= 1'b0;
      r_err      <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          // Only a FRAME-marked slot can start collection. Stray data is dropped.
          if (VALID && FRAME) begin
            r_shadow <= w_first;
            r_slot   <= SW'(1);
            r_stall  <= '0;
            r_state  <= ST_RECV;
          end
        end

        ST_RECV: begin
          if (VALID && FRAME) begin
            // Early FRAME: drop the partial frame and restart at slot 0.
            // This branch is checked first, so it wins over a timeout
            // that happens in the same cycle.
            r_err    <= 1'b1;
            r_shadow <= w_first;
            r_slot   <= SW'(1);
            r_stall  <= '0;
          end else if (VALID) begin
            r_stall <= '0;
            if (r_slot == LAST_SLOT) begin
              // Frame complete: publish it and get ready for a
              // back-to-back FRAME on the next cycle.
              r_dout     <= w_frame_full;
              r_dout_vld <= 1'b1;
              r_shadow   <= '0;
              r_slot     <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_shadow[r_slot] <= w_din;
              r_slot           <= r_slot + SW'(1);
            end
          end else if (r_stall == STALL_LIM) begin
            // Idle for too long mid-frame: abort. DOUT keeps its last value.
            r_err    <= 1'b1;
            r_shadow <= '0;
            r_slot   <= '0;
            r_stall  <= '0;
            r_state  <= ST_IDLE;
          end else begin
            r_stall <= r_stall + 8'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DOUT     = r_dout;
  assign DOUT_VLD = r_dout_vld;
  assign SLOT     = r_slot;
  assign ERR      = r_err;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed and randomized checks of tdm_demux (N_CH=4, FRAME_TO=8)
// against a queue-based model of frame collection.
module tb_tdm_demux;

  localparam int N_CH     = 4;
  localparam int FRAME_TO = 8;

  logic            clk;
  logic            rst_n;
  logic            din;
  logic            valid;
  logic            frame;
  logic [N_CH-1:0] dout;
  logic            dout_vld;
  logic [1:0]      slot;
  logic            err;

  int total = 0;
  int bad   = 0;

  // Model state: slots collected so far in the current frame. The queue is
  // empty when no frame is in progress.
  bit              m_bits[$];
  int              m_idle;
  logic [N_CH-1:0] m_dout;
  logic            m_vld;
  logic            m_err;

  tdm_demux #(.N_CH(N_CH), .FRAME_TO(FRAME_TO)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .DIN      (din),
    .VALID    (valid),
    .FRAME    (frame),
    .DOUT     (dout),
    .DOUT_VLD (dout_vld),
    .SLOT     (slot),
    .ERR      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_idle = 0;
    m_dout = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
  endtask

  // Apply the frame rules to one clock cycle of input.
  task automatic model_step(input bit v, input bit f, input bit d);
    m_vld = 1'b0;
    m_err = 1'b0;
    if (v && f) begin
      if (m_bits.size() != 0) m_err = 1'b1;
      m_bits.delete();
      m_bits.push_back(d);
      m_idle = 0;
    end else if (v) begin
      if (m_bits.size() != 0) begin
        m_bits.push_back(d);
        m_idle = 0;
        if (m_bits.size() == N_CH) begin
          for (int k = 0; k < N_CH; k++) m_dout[k] = m_bits[k];
          m_vld = 1'b1;
          m_bits.delete();
        end
      end
    end else if (m_bits.size() != 0) begin
      m_idle++;
      if (m_idle == FRAME_TO) begin
        m_err = 1'b1;
        m_bits.delete();
        m_idle = 0;
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".dout"},     32'(dout),     32'(m_dout));
    chk({ctx, ".dout_vld"}, 32'(dout_vld), 32'(m_vld));
    chk({ctx, ".err"},      32'(err),      32'(m_err));
    chk({ctx, ".slot"},     32'(slot),     32'(m_bits.size()));
    chk({ctx, ".excl"},     32'(dout_vld & err), 32'd0);
  endtask

  // Drive one cycle, advance the model at the edge, and sample 1 time unit later.
  task automatic step(input string ctx, input bit v, input bit f, input bit d);
    valid = v;
    frame = f;
    din   = d;
    @(posedge clk);
    model_step(v, f, d);
    #1;
    check_outputs(ctx);
  endtask

  // Send a full frame with no gaps. Bits are given in slot order: d[0] is slot 0.
  task automatic send_frame(input string ctx, input logic [N_CH-1:0] d);
    for (int k = 0; k < N_CH; k++) step(ctx, 1'b1, (k == 0), d[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    valid = 1'b0;
    frame = 1'b0;
    din   = 1'b0;
    rst_n = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: slots 1,0,1,1 give DOUT=1101 one cycle after the last slot.
    send_frame("basic", 4'b1101);
    chk("basic.const_dout", 32'(dout), 32'hd);
    chk("basic.const_vld",  32'(dout_vld), 32'd1);
    step("basic_after", 1'b0, 1'b0, 1'b0);
    chk("basic.vld_one_cycle", 32'(dout_vld), 32'd0);

    // Stall of 3 cycles between slots 1 and 2. This is under the timeout.
    step("stall3", 1'b1, 1'b1, 1'b0);
    step("stall3", 1'b1, 1'b0, 1'b1);
    repeat (3) step("stall3_gap", 1'b0, 1'b0, 1'b0);
    step("stall3", 1'b1, 1'b0, 1'b1);
    step("stall3", 1'b1, 1'b0, 1'b0);
    chk("stall3.const_dout", 32'(dout), 32'h6);

    // Back-to-back frames 1101 then 0010 with no gap.
    send_frame("b2b_a", 4'b1101);
    chk("b2b.first", 32'(dout), 32'hd);
    send_frame("b2b_b", 4'b0010);
    chk("b2b.second", 32'(dout), 32'h2);

    // Early FRAME at slot 2, then the frame 0110 completes.
    step("early", 1'b1, 1'b1, 1'b1);
    step("early", 1'b1, 1'b0, 1'b1);
    step("early_restart", 1'b1, 1'b1, 1'b0);
    chk("early.err_const", 32'(err), 32'd1);
    chk("early.dout_held", 32'(dout), 32'h2);
    step("early", 1'b1, 1'b0, 1'b1);
    step("early", 1'b1, 1'b0, 1'b1);
    step("early", 1'b1, 1'b0, 1'b0);
    chk("early.dout_new", 32'(dout), 32'h6);

    // Timeout: 8 idle cycles after slot 1. A later VALID without FRAME is ignored.
    step("tmo", 1'b1, 1'b1, 1'b1);
    step("tmo", 1'b1, 1'b0, 1'b1);
    repeat (FRAME_TO) step("tmo_gap", 1'b0, 1'b0, 1'b0);
    chk("tmo.err_const", 32'(err), 32'd1);
    chk("tmo.slot_const", 32'(slot), 32'd0);
    step("tmo_ignored", 1'b1, 1'b0, 1'b1);
    step("tmo_ignored", 1'b1, 1'b0, 1'b1);

    // Timeout boundary: FRAME_TO-1 idle cycles must not abort.
    step("tmo_edge", 1'b1, 1'b1, 1'b1);
    repeat (FRAME_TO - 1) step("tmo_edge_gap", 1'b0, 1'b0, 1'b0);
    send_frame("tmo_edge_dummy", 4'b1111);

    // Asynchronous reset in the middle of a frame at slot 2.
    step("arst", 1'b1, 1'b1, 1'b1);
    step("arst", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.dout_async", 32'(dout), 32'd0);
    chk("arst.slot_async", 32'(slot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("arst_release", 1'b0, 1'b0, 1'b0);
    step("arst_noframe", 1'b1, 1'b0, 1'b1);
    step("arst_noframe", 1'b1, 1'b0, 1'b1);

    // Randomized traffic, with some long idle bursts to trigger timeouts.
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 39) begin
        r = $urandom_range(FRAME_TO - 2, FRAME_TO + 2);
        repeat (r) step("rand_burst", 1'b0, 1'b0, 1'b0);
      end
      r = $urandom_range(0, 99);
      if (r < 20)      step("rand", 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      else if (r < 32) step("rand", 1'b1, 1'b1, 1'($urandom_range(0, 1)));
      else             step("rand", 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter N_CH, default 4, giving the number of demultiplexed output channels (legal 2..16).
REQ-002 SHALL have parameter FRAME_TO, default 8, giving the maximum idle cycles (VALID low) tolerated mid-frame before abort (legal 1..255).
REQ-003 SHALL have port CLK  input  xbit 1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  xbit 1  reset, asynchronous, active-low.
REQ-005 SHALL have port DIN  input  xbit 1  serial time-multiplexed data, one channel slot per accepted cycle.
REQ-006 SHALL have port VALID  input  xbit 1  DIN is meaningful this cycle.
REQ-007 SHALL have port FRAME  input  xbit 1  marks slot 0 of a frame; qualified by VALID.
REQ-008 SHALL have port DOUT  output  xbit N_CH  registered per-channel outputs, bit k = slot k of last complete frame.
REQ-009 SHALL have port DOUT_VLD  output  xbit 1  one-cycle pulse when DOUT is updated.
REQ-010 SHALL have port SLOT  output  xbit ceil(log2 N_CH)  index of the next expected slot.
REQ-011 SHALL have port ERR  output  xbit 1  one-cycle pulse on frame abort (early FRAME or timeout).

Function
REQ-012 SHALL implement states IDLE and RECV.
REQ-013 In IDLE, VALID=1 & FRAME=1 SHALL capture DIN into shadow bit 0, set SLOT=1, enter RECV; VALID=1 & FRAME=0 SHALL be ignored.
REQ-014 In RECV, VALID=1 & FRAME=0 SHALL capture DIN into shadow bit SLOT and increment SLOT.
REQ-015 In RECV, VALID=0 SHALL hold SLOT and shadow and increment a stall counter; any accepted VALID cycle SHALL clear the stall counter.
REQ-016 When slot N_CH-1 is captured, DOUT SHALL take the full shadow value and DOUT_VLD SHALL be 1 on the next rising edge (latency 1 cycle after last slot), SLOT SHALL wrap to 0, state SHALL go IDLE.
REQ-017 Capturing the last slot with VALID=1 & FRAME=1 on the following cycle SHALL start a new frame with no lost cycle (back-to-back frames).
REQ-018 In RECV, VALID=1 & FRAME=1 (early frame) SHALL pulse ERR, discard the partial shadow, capture DIN as slot 0 of a new frame, set SLOT=1, remain RECV; DOUT SHALL not change.
REQ-019 In RECV, stall counter reaching FRAME_TO SHALL pulse ERR, clear shadow, set SLOT=0, go IDLE; DOUT SHALL not change.
REQ-020 If timeout and VALID=1 & FRAME=1 coincide, the early-frame rule (REQ-018) SHALL take precedence and ERR SHALL pulse once.
REQ-021 DOUT SHALL hold its value between updates; unused shadow bits SHALL never reach DOUT.
REQ-022 DOUT_VLD and ERR SHALL never be 1 in the same cycle.
REQ-023 X/Z on DIN while VALID=1 SHALL be captured as 0.

Reset
REQ-024 RST_N=0 SHALL immediately, independent of CLK, force state IDLE, SLOT=0, DOUT=0, DOUT_VLD=0, ERR=0, shadow=0, stall counter=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame without pulsing ERR or DOUT_VLD.
REQ-026 First capture after RST_N deassertion SHALL require a new FRAME.

Verification
REQ-027 N_CH=4: FRAME+VALID with DIN=1,0,1,1 on 4 consecutive cycles -> next cycle DOUT=4'b1101, DOUT_VLD=1 for exactly one cycle, SLOT=0.
REQ-028 Same frame with VALID low for 3 cycles between slots 1 and 2 (FRAME_TO=8) -> DOUT=4'b1101 delivered 3 cycles later, ERR stays 0.
REQ-029 Two frames back-to-back (1101 then 0010) -> DOUT_VLD pulses 4 cycles apart, DOUT=1101 then 0010.
REQ-030 FRAME re-asserted at slot 2 then full frame 0110 -> ERR one pulse, DOUT unchanged until it becomes 0110.
REQ-031 Stall of 8 cycles after slot 1 with FRAME_TO=8 -> ERR pulse, SLOT=0, DOUT unchanged; next VALID without FRAME ignored.
REQ-032 RST_N low asynchronously at slot 2 -> DOUT=0, SLOT=0 before next CLK edge; no ERR/DOUT_VLD pulse after release.
